// File: rtl/dmem_map_pkg.sv
// Address map, lock-state encoding and KEY_STATUS bit positions shared by the
// data-memory responder and the firmware header.
package dmem_map_pkg;

  localparam logic [31:0] KEY_STATUS_ADDR = 32'h0000_1000;
  localparam logic [31:0] KEY_DATA_ADDR   = 32'h0000_1001;
  localparam logic [31:0] KEY_POP_ADDR    = 32'h0000_1002;
  localparam logic [31:0] LOCK_CMD_ADDR   = 32'h0000_1003;

  localparam int KS_NONEMPTY_BIT = 0;
  localparam int KS_COUNT_LSB    = 1;
  localparam int KS_COUNT_W      = 4;
  localparam int KS_OVERFLOW_BIT = 8;

  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    UNLOCKING = 2'd1,
    UNLOCKED  = 2'd2,
    LOCKING   = 2'd3
  } lock_state_e;

  // True when the latch is open or heading there.
  function automatic logic lock_target_open(input lock_state_e s);
    return (s == UNLOCKING) || (s == UNLOCKED);
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Keypad code FIFO: push from the scanner, pop on a processor store,
// sticky overflow when a code arrives with no room.
module keypad_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  input  logic          clr_ovf_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          overflow_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, do_pop, do_push;

  assign empty_o    = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push_i && (!full || do_pop);
  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (clr_ovf_i)          ovf_d = 1'b0;
    if (push_i && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM, keypad FIFO registers and the lock servo.
// Reads are side-effect free; every side effect is triggered by a store.
module dmem_mmio_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_WORDS      = 4096,
  parameter int FIFO_DEPTH     = 8,
  parameter int PWM_PERIOD     = 2_000_000,
  parameter int PULSE_LOCKED   = 100_000,
  parameter int PULSE_UNLOCKED = 200_000,
  parameter int MOVE_FRAMES    = 25
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  input  logic        keypad_valid,
  input  logic [3:0]  keypad_code,
  output logic        servo_pwm,
  output logic        lock_open
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(PWM_PERIOD);
  localparam int MW = $clog2(MOVE_FRAMES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic is_ram, wr_status, wr_pop, wr_lock;

  assign is_ram    = (address_dmem < 32'(RAM_WORDS));
  assign wr_status = wren && (address_dmem == KEY_STATUS_ADDR);
  assign wr_pop    = wren && (address_dmem == KEY_POP_ADDR);
  assign wr_lock   = wren && (address_dmem == LOCK_CMD_ADDR);

  logic [3:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_ovf;

  keypad_fifo #(.DEPTH(FIFO_DEPTH), .DW(4)) u_keypad_fifo (
    .clk        (clk_100mhz),
    .rst        (reset),
    .push_i     (keypad_valid),
    .din_i      (keypad_code),
    .pop_i      (wr_pop),
    .clr_ovf_i  (wr_status),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_ovf)
  );

  // RAM contents survive reset, so this array has no reset branch.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk_100mhz) begin
    if (wren && is_ram) ram[address_dmem[AW-1:0]] <= data;
  end

  lock_state_e state_q, state_d;
  logic [FW-1:0] frame_q, frame_d, pulse_d;
  logic [MW-1:0] move_q, move_d;
  logic          pwm_q, pwm_d;
  logic [31:0]   status, q_dmem_q, q_dmem_d;

  always_comb begin
    status = '0;
    status[KS_NONEMPTY_BIT]              = !fifo_empty;
    status[KS_COUNT_LSB +: KS_COUNT_W]   = KS_COUNT_W'(fifo_count);
    status[KS_OVERFLOW_BIT]              = fifo_ovf;
    q_dmem_d = '0;
    if (is_ram) q_dmem_d = ram[address_dmem[AW-1:0]];
    else begin
      case (address_dmem)
        KEY_STATUS_ADDR: q_dmem_d = status;
        KEY_DATA_ADDR:   q_dmem_d = {28'b0, fifo_head};
        LOCK_CMD_ADDR:   q_dmem_d = {30'b0, state_q};
        default:         q_dmem_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    frame_d = (frame_q == FW'(PWM_PERIOD - 1)) ? '0 : frame_q + 1'b1;
    if ((state_q == UNLOCKING || state_q == LOCKING) && frame_q == FW'(PWM_PERIOD - 1)) begin
      if (move_q == MW'(MOVE_FRAMES - 1)) begin
        move_d  = '0;
        state_d = (state_q == UNLOCKING) ? UNLOCKED : LOCKED;
      end else begin
        move_d = move_q + 1'b1;
      end
    end
    // A request matching the current target leaves the move running untouched.
    if (wr_lock) begin
      if (data[0] && !lock_target_open(state_q)) begin
        state_d = UNLOCKING;
        frame_d = '0;
        move_d  = '0;
      end else if (!data[0] && lock_target_open(state_q)) begin
        state_d = LOCKING;
        frame_d = '0;
        move_d  = '0;
      end
    end
    pulse_d = lock_target_open(state_d) ? FW'(PULSE_UNLOCKED) : FW'(PULSE_LOCKED);
    pwm_d   = (frame_d < pulse_d);
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q  <= LOCKED;
      frame_q  <= '0;
      move_q   <= '0;
      pwm_q    <= 1'b0;
      q_dmem_q <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      move_q   <= move_d;
      pwm_q    <= pwm_d;
      q_dmem_q <= q_dmem_d;
    end
  end

  assign q_dmem    = q_dmem_q;
  assign servo_pwm = pwm_q;
  assign lock_open = (state_q == UNLOCKED);

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder against a queue/time based model.
module tb_dmem_mmio_responder;
  import dmem_map_pkg::*;

  localparam int PER = 100, PL = 10, PU = 20, MF = 3, MOVE = PER * MF;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_2000;

  logic        clk_100mhz = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = '0, data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic        keypad_valid = 1'b0;
  logic [3:0]  keypad_code = '0;
  logic        servo_pwm, lock_open;

  dmem_mmio_responder #(
    .RAM_WORDS(4096), .FIFO_DEPTH(8), .PWM_PERIOD(PER),
    .PULSE_LOCKED(PL), .PULSE_UNLOCKED(PU), .MOVE_FRAMES(MF)
  ) dut (
    .clk_100mhz(clk_100mhz), .reset(reset), .address_dmem(address_dmem),
    .data(data), .wren(wren), .q_dmem(q_dmem), .keypad_valid(keypad_valid),
    .keypad_code(keypad_code), .servo_pwm(servo_pwm), .lock_open(lock_open)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Reference model
  logic [31:0] mram [int];
  int unsigned mq[$];
  bit          movf = 0;
  int          ms = 0, mstart = 0;
  int          checks = 0, fails = 0;

  // Lock state after edge number c: a move finishes MOVE edges after its start.
  function automatic int st_at(input int c);
    if (ms == 1 && c - mstart >= MOVE) return 2;
    if (ms == 3 && c - mstart >= MOVE) return 0;
    return ms;
  endfunction

  function automatic void mread(input logic [31:0] a, input int c, output logic [31:0] v, output bit known);
    int unsigned n;
    n = mq.size();
    known = 1;
    v = '0;
    if (a < 32'd4096) begin
      if (mram.exists(int'(a))) v = mram[int'(a)];
      else known = 0;
    end else if (a == KEY_STATUS_ADDR) v = {23'b0, movf, 3'b0, 4'(n), n != 0};
    else if (a == KEY_DATA_ADDR) v = (n != 0) ? mq[0] : 32'd0;
    else if (a == LOCK_CMD_ADDR) v = 32'(st_at(c));
  endfunction

  // One bus cycle: drive at a falling edge, sample q_dmem at the next falling edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic kv,
                      input logic [3:0] kc, output logic [31:0] got, output logic [31:0] exp, output bit known);
    int c, s;
    bit popd;
    address_dmem = a; data = d; wren = we; keypad_valid = kv; keypad_code = kc;
    mread(a, cyc, exp, known);
    @(negedge clk_100mhz);
    c = cyc;
    if (we) begin
      if (a < 32'd4096) mram[int'(a)] = d;
      if (a == KEY_STATUS_ADDR) movf = 0;
      if (a == LOCK_CMD_ADDR) begin
        s = st_at(c - 1);
        ms = s;
        if (d[0] && (s == 0 || s == 3)) begin ms = 1; mstart = c; end
        else if (!d[0] && (s == 1 || s == 2)) begin ms = 3; mstart = c; end
      end
    end
    popd = we && (a == KEY_POP_ADDR) && (mq.size() > 0);
    if (popd) void'(mq.pop_front());
    if (kv) begin
      if (mq.size() < 8) mq.push_back(32'(kc));
      else movf = 1;
    end
    got = q_dmem;
    wren = 1'b0;
    keypad_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [31:0] g, e;
    bit k;
    repeat (n) step(IDLE_ADDR, 0, 0, 0, 0, g, e, k);
  endtask

  task automatic test_reset;
    logic [31:0] g, e;
    bit k;
    repeat (3) @(negedge clk_100mhz);
    checks++; if (q_dmem !== 32'd0) begin fails++; $display("FAIL rst_q got=%h exp=0", q_dmem); end
    checks++; if (lock_open !== 1'b0) begin fails++; $display("FAIL rst_lock_open got=%b exp=0", lock_open); end
    checks++; if (servo_pwm !== 1'b0) begin fails++; $display("FAIL rst_pwm got=%b exp=0", servo_pwm); end
    reset = 1'b0;
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL rst_status got=%h exp=%h", g, e); end
    checks++; if (servo_pwm !== 1'b1) begin fails++; $display("FAIL rst_pwm_rise got=%b exp=1", servo_pwm); end
  endtask

  task automatic test_ram;
    logic [31:0] g, e;
    bit k;
    step(32'h5, 32'hDEAD_BEEF, 1, 0, 0, g, e, k);
    step(32'h5, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_rd got=%h exp=deadbeef", g); end
    step(32'h5, 32'h1234_5678, 1, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL ram_rbw got=%h exp=%h", g, e); end
    step(32'h4, 32'h0000_A5A5, 1, 0, 0, g, e, k);
    step(32'h1004, 32'hFFFF_FFFF, 1, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL unmapped_rd got=%h exp=%h", g, e); end
    step(32'h4, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL ram_no_alias got=%h exp=%h", g, e); end
    step(32'h0FFF, 0, 0, 0, 0, g, e, k);
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if ($isunknown(g) || g !== e) begin fails++; $display("FAIL status_after_fff got=%h exp=%h", g, e); end
  endtask

  task automatic test_keypad;
    logic [31:0] g, e;
    bit k;
    for (int i = 1; i <= 3; i++) step(IDLE_ADDR, 0, 0, 1, 4'(i), g, e, k);
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'h7) begin fails++; $display("FAIL key_status got=%h exp=7", g); end
    for (int i = 0; i < 2; i++) begin
      step(KEY_DATA_ADDR, 0, 0, 0, 0, g, e, k);
      checks++; if (g !== 32'h1) begin fails++; $display("FAIL key_data_nopop got=%h exp=1", g); end
    end
    step(KEY_POP_ADDR, 0, 1, 0, 0, g, e, k);
    step(KEY_DATA_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL key_data_pop got=%h exp=%h", g, e); end
  endtask

  task automatic test_overflow;
    logic [31:0] g, e;
    bit k;
    logic [3:0] first;
    while (mq.size() > 0) step(KEY_POP_ADDR, 0, 1, 0, 0, g, e, k);
    first = 4'($urandom_range(15));
    step(IDLE_ADDR, 0, 0, 1, first, g, e, k);
    repeat (8) step(IDLE_ADDR, 0, 0, 1, 4'($urandom_range(15)), g, e, k);
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'h111) begin fails++; $display("FAIL ovf_status got=%h exp=111", g); end
    step(KEY_DATA_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== {28'b0, first}) begin fails++; $display("FAIL ovf_head got=%h exp=%h", g, first); end
    step(KEY_STATUS_ADDR, $urandom, 1, 0, 0, g, e, k);
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'h011) begin fails++; $display("FAIL ovf_clear got=%h exp=011", g); end
  endtask

  task automatic test_same_edge;
    logic [31:0] g, e;
    bit k;
    logic [3:0] kc;
    step(KEY_POP_ADDR, 0, 1, 1, 4'($urandom_range(15)), g, e, k);
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'h011) begin fails++; $display("FAIL full_pushpop got=%h exp=011", g); end
    step(KEY_DATA_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL full_pushpop_head got=%h exp=%h", g, e); end
    while (mq.size() > 0) step(KEY_POP_ADDR, 0, 1, 0, 0, g, e, k);
    kc = 4'($urandom_range(1, 15));
    step(KEY_POP_ADDR, 0, 1, 1, kc, g, e, k);
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'h003) begin fails++; $display("FAIL empty_pushpop got=%h exp=003", g); end
    step(KEY_DATA_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== {28'b0, kc}) begin fails++; $display("FAIL empty_pushpop_head got=%h exp=%h", g, kc); end
  endtask

  task automatic test_lock;
    logic [31:0] g, e;
    bit k;
    int hi, bad;
    step(LOCK_CMD_ADDR, 1, 1, 0, 0, g, e, k);
    step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL lock_unlocking got=%h exp=%h", g, e); end
    hi = 0;
    repeat (PER) begin idle(1); hi += int'(servo_pwm); end
    checks++; if (hi !== PU) begin fails++; $display("FAIL pwm_unlock got=%0d exp=%0d", hi, PU); end
    checks++; if (lock_open !== 1'b0) begin fails++; $display("FAIL open_midmove got=%b exp=0", lock_open); end
    while (cyc - mstart < MOVE) idle(1);
    checks++; if (lock_open !== (st_at(cyc) == 2)) begin fails++; $display("FAIL open_done got=%b exp=1", lock_open); end
    step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL lock_unlocked got=%h exp=%h", g, e); end
    step(LOCK_CMD_ADDR, 1, 1, 0, 0, g, e, k);
    step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL lock_repeat_unlock got=%h exp=%h", g, e); end
    step(LOCK_CMD_ADDR, 0, 1, 0, 0, g, e, k);
    step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL lock_locking got=%h exp=%h", g, e); end
    hi = 0;
    repeat (PER) begin idle(1); hi += int'(servo_pwm); end
    checks++; if (hi !== PL) begin fails++; $display("FAIL pwm_lock got=%0d exp=%0d", hi, PL); end
    while (cyc - mstart < MOVE) idle(1);
    step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e || lock_open !== 1'b0) begin fails++; $display("FAIL lock_locked got=%h/%b exp=%h/0", g, lock_open, e); end
    // Reverse a move halfway, then repeat the same request: completion time must not move.
    step(LOCK_CMD_ADDR, 1, 1, 0, 0, g, e, k);
    while (cyc - mstart < 150) idle(1);
    step(LOCK_CMD_ADDR, 0, 1, 0, 0, g, e, k);
    step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== e) begin fails++; $display("FAIL lock_reverse got=%h exp=%h", g, e); end
    idle(100);
    step(LOCK_CMD_ADDR, 0, 1, 0, 0, g, e, k);
    bad = 0;
    repeat (MOVE) begin
      step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
      if (g !== e) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL lock_no_restart got=%0d bad reads exp=0", bad); end
  endtask

  task automatic test_random;
    logic [31:0] g, e, a, d;
    bit k;
    logic we, kv;
    for (int i = 0; i < 400; i++) begin
      we = 0; d = $urandom;
      kv = ($urandom_range(3) == 0);
      case ($urandom_range(7))
        0: begin a = ($urandom_range(1)) ? 32'($urandom_range(15)) : 32'($urandom_range(4080, 4095)); we = 1; end
        1: a = ($urandom_range(1)) ? 32'($urandom_range(15)) : 32'($urandom_range(4080, 4095));
        2: a = IDLE_ADDR;
        3: begin a = KEY_POP_ADDR; we = 1; end
        4: a = KEY_DATA_ADDR;
        5: a = KEY_STATUS_ADDR;
        6: begin a = KEY_STATUS_ADDR; we = 1; end
        default: begin a = 32'($urandom_range(32'h1004, 32'h1FFFF)); we = 1'($urandom_range(1)); end
      endcase
      step(a, d, we, kv, 4'($urandom_range(15)), g, e, k);
      if (k) begin
        checks++;
        if (g !== e) begin fails++; $display("FAIL random addr=%h got=%h exp=%h", a, g, e); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] g, e;
    bit k;
    while (mq.size() > 0) step(KEY_POP_ADDR, 0, 1, 0, 0, g, e, k);
    repeat (3) step(IDLE_ADDR, 0, 0, 1, 4'($urandom_range(1, 15)), g, e, k);
    step(LOCK_CMD_ADDR, 1, 1, 0, 0, g, e, k);
    idle(50);
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    #2 reset = 1'b1;
    #1;
    checks++; if (q_dmem !== 32'd0) begin fails++; $display("FAIL midrst_q got=%h exp=0", q_dmem); end
    checks++; if (lock_open !== 1'b0 || servo_pwm !== 1'b0) begin fails++; $display("FAIL midrst_outs got=%b%b exp=00", lock_open, servo_pwm); end
    mq.delete(); movf = 0; ms = 0;
    @(negedge clk_100mhz);
    reset = 1'b0;
    step(KEY_STATUS_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'd0) begin fails++; $display("FAIL midrst_status got=%h exp=0", g); end
    step(LOCK_CMD_ADDR, 0, 0, 0, 0, g, e, k);
    checks++; if (g !== 32'd0) begin fails++; $display("FAIL midrst_state got=%h exp=0", g); end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_keypad;
    test_overflow;
    test_same_edge;
    test_lock;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=no finish exp=finish");
    $fatal(1, "timeout");
  end

endmodule
